// File: rtl/dma_host_ctrl.sv
// ============================================================================
// Module  : dma_host_ctrl
// Brief   : Two independent line-granular DMA channels (memory->peripheral read,
//           peripheral->memory write), each with a show-ahead line FIFO.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dma_host_fifo #(
  parameter int DW    = 512,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] head_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !(rst || clr_i)) mem_q[wptr_q] <= data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

module dma_host_ctrl #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SIZE_WIDTH-1:0] rd_size,
  input  logic                  rd_go,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_done,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] wr_size,
  input  logic                  wr_go,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  wr_done,
  output logic                  mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_rd_req_addr,
  input  logic                  mem_rd_req_ready,
  input  logic                  mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_rsp_data,
  output logic                  mem_wr_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_wr_req_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_req_data,
  input  logic                  mem_wr_req_ready,
  input  logic                  mem_wr_rsp_valid
);
  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   C_DEPTH = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_e;

  // ---------------- read channel ----------------
  state_e                rd_state_q;
  logic [ADDR_WIDTH-1:0] rd_base_q;
  logic [SIZE_WIDTH-1:0] rd_size_q, rd_issued_q, rd_popped_q;
  logic [CW-1:0]         rd_out_q, rd_cnt;
  logic                  rd_done_q;
  logic [DATA_WIDTH-1:0] rd_head;
  logic                  rd_active, rd_fire, rd_push, rd_pop, rd_clr;
  logic [CW:0]           rd_inflight;

  assign rd_active   = (rd_state_q == ACTIVE);
  assign rd_clr      = rd_go && !rd_active;
  assign rd_fire     = mem_rd_req_valid && mem_rd_req_ready;
  // outstanding != 0 guards against a stray response overrunning the FIFO
  assign rd_push     = rd_active && mem_rd_rsp_valid && (rd_out_q != '0);
  assign rd_pop      = rd_en && (rd_cnt != '0);
  assign rd_inflight = {1'b0, rd_out_q} + {1'b0, rd_cnt};

  assign mem_rd_req_valid = rd_active && (rd_issued_q < rd_size_q) && (rd_inflight < C_DEPTH);
  assign mem_rd_req_addr  = mem_rd_req_valid ? rd_base_q + (ADDR_WIDTH'(rd_issued_q) << 6) : '0;
  assign empty            = (rd_cnt == '0);
  assign rd_data          = empty ? '0 : rd_head;
  assign rd_done          = rd_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q  <= IDLE;
      rd_base_q   <= '0;
      rd_size_q   <= '0;
      rd_issued_q <= '0;
      rd_popped_q <= '0;
      rd_out_q    <= '0;
      rd_done_q   <= 1'b0;
    end else begin
      case (rd_state_q)
        ACTIVE: begin
          if (rd_fire) rd_issued_q <= rd_issued_q + 1'b1;
          if (rd_pop)  rd_popped_q <= rd_popped_q + 1'b1;
          rd_out_q <= rd_out_q + CW'(rd_fire) - CW'(rd_push);
          if (rd_popped_q == rd_size_q) begin
            rd_state_q <= DONE;
            rd_done_q  <= 1'b1;
          end
        end
        default: begin
          if (rd_go) begin
            rd_base_q   <= rd_addr;
            rd_size_q   <= rd_size;
            rd_issued_q <= '0;
            rd_popped_q <= '0;
            rd_out_q    <= '0;
            rd_done_q   <= 1'b0;
            rd_state_q  <= ACTIVE;
          end
        end
      endcase
    end
  end

  dma_host_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .CW(CW)) u_rd_fifo (
    .clk(clk), .rst(rst), .clr_i(rd_clr), .push_i(rd_push), .pop_i(rd_pop),
    .data_i(mem_rd_rsp_data), .head_o(rd_head), .count_o(rd_cnt)
  );

  // ---------------- write channel ----------------
  state_e                wr_state_q;
  logic [ADDR_WIDTH-1:0] wr_base_q;
  logic [SIZE_WIDTH-1:0] wr_size_q, wr_accepted_q, wr_issued_q, wr_acks_q;
  logic                  wr_done_q;
  logic [CW-1:0]         wr_cnt;
  logic [DATA_WIDTH-1:0] wr_head;
  logic                  wr_active, wr_push, wr_pop, wr_clr;

  assign wr_active = (wr_state_q == ACTIVE);
  assign wr_clr    = wr_go && !wr_active;
  assign full      = !wr_active || (wr_cnt == CW'(FIFO_DEPTH)) || (wr_accepted_q == wr_size_q);
  assign wr_push   = wr_en && !full;
  assign wr_pop    = mem_wr_req_valid && mem_wr_req_ready;

  assign mem_wr_req_valid = (wr_cnt != '0);
  assign mem_wr_req_addr  = mem_wr_req_valid ? wr_base_q + (ADDR_WIDTH'(wr_issued_q) << 6) : '0;
  assign mem_wr_req_data  = mem_wr_req_valid ? wr_head : '0;
  assign wr_done          = wr_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q    <= IDLE;
      wr_base_q     <= '0;
      wr_size_q     <= '0;
      wr_accepted_q <= '0;
      wr_issued_q   <= '0;
      wr_acks_q     <= '0;
      wr_done_q     <= 1'b0;
    end else begin
      case (wr_state_q)
        ACTIVE: begin
          if (wr_push)          wr_accepted_q <= wr_accepted_q + 1'b1;
          if (wr_pop)           wr_issued_q   <= wr_issued_q + 1'b1;
          if (mem_wr_rsp_valid) wr_acks_q     <= wr_acks_q + 1'b1;
          if (wr_acks_q == wr_size_q) begin
            wr_state_q <= DONE;
            wr_done_q  <= 1'b1;
          end
        end
        default: begin
          if (wr_go) begin
            wr_base_q     <= wr_addr;
            wr_size_q     <= wr_size;
            wr_accepted_q <= '0;
            wr_issued_q   <= '0;
            wr_acks_q     <= '0;
            wr_done_q     <= 1'b0;
            wr_state_q    <= ACTIVE;
          end
        end
      endcase
    end
  end

  dma_host_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .CW(CW)) u_wr_fifo (
    .clk(clk), .rst(rst), .clr_i(wr_clr), .push_i(wr_push), .pop_i(wr_pop),
    .data_i(wr_data), .head_o(wr_head), .count_o(wr_cnt)
  );
endmodule

`default_nettype wire

// File: tb/tb_dma_host_ctrl.sv
// ============================================================================
// Module  : tb_dma_host_ctrl
// Brief   : Directed self-checking bench for dma_host_ctrl with a simple memory model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dma_host_ctrl;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   rd_addr = '0, wr_addr = '0;
  logic [42:0]   rd_size = '0, wr_size = '0;
  logic          rd_go = 1'b0, wr_go = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic [511:0]  wr_data = '0;
  logic [511:0]  rd_data;
  logic          empty, rd_done, full, wr_done;
  logic          mem_rd_req_valid, mem_wr_req_valid;
  logic [63:0]   mem_rd_req_addr, mem_wr_req_addr;
  logic [511:0]  mem_wr_req_data;
  logic          mem_rd_req_ready = 1'b1, mem_wr_req_ready = 1'b1;
  logic          mem_rd_rsp_valid = 1'b0, mem_wr_rsp_valid = 1'b0;
  logic [511:0]  mem_rd_rsp_data = '0;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_lat = 2;
  int ack_cnt = 0;
  int rd_due[$];
  logic [63:0]  rd_pend[$];
  logic [63:0]  rd_log[$];
  int wr_due[$];
  logic [63:0]  wr_alog[$];
  logic [511:0] wr_dlog[$];

  dma_host_ctrl dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_size(rd_size), .rd_go(rd_go), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
    .wr_addr(wr_addr), .wr_size(wr_size), .wr_go(wr_go), .wr_en(wr_en),
    .wr_data(wr_data), .full(full), .wr_done(wr_done),
    .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_addr(mem_rd_req_addr),
    .mem_rd_req_ready(mem_rd_req_ready), .mem_rd_rsp_valid(mem_rd_rsp_valid),
    .mem_rd_rsp_data(mem_rd_rsp_data),
    .mem_wr_req_valid(mem_wr_req_valid), .mem_wr_req_addr(mem_wr_req_addr),
    .mem_wr_req_data(mem_wr_req_data), .mem_wr_req_ready(mem_wr_req_ready),
    .mem_wr_rsp_valid(mem_wr_rsp_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] pat(input logic [63:0] a);
    return {8{a}};
  endfunction

  function automatic logic [511:0] wd(input int i);
    return {16{32'hA5A5_0000 + 32'(i)}};
  endfunction

  function automatic logic [63:0] rd_at(input int i);
    if (i < rd_log.size()) return rd_log[i];
    return 64'hBAD;
  endfunction

  // Memory model: decisions at negedge for the upcoming rising edge.
  initial forever begin
    @(negedge clk);
    if (mem_rd_req_valid && mem_rd_req_ready) begin
      rd_log.push_back(mem_rd_req_addr);
      rd_pend.push_back(mem_rd_req_addr);
      rd_due.push_back(cyc + 1 + rd_lat);
    end
    if (rd_due.size() > 0 && rd_due[0] == cyc + 1) begin
      mem_rd_rsp_valid = 1'b1;
      mem_rd_rsp_data  = pat(rd_pend[0]);
      rd_due.delete(0);
      rd_pend.delete(0);
    end else begin
      mem_rd_rsp_valid = 1'b0;
      mem_rd_rsp_data  = '0;
    end
    if (mem_wr_req_valid && mem_wr_req_ready) begin
      wr_alog.push_back(mem_wr_req_addr);
      wr_dlog.push_back(mem_wr_req_data);
      wr_due.push_back(cyc + 1 + 3);
    end
    if (wr_due.size() > 0 && wr_due[0] == cyc + 1) begin
      mem_wr_rsp_valid = 1'b1;
      ack_cnt++;
      wr_due.delete(0);
    end else begin
      mem_wr_rsp_valid = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_lines(input int n, input logic [63:0] base, input string tag);
    for (int i = 0; i < n; i++) begin
      int b = 0;
      while (empty && b < 100) begin tick(); b++; end
      check($sformatf("%s_data%0d", tag, i), rd_data, pat(base + 64'(64 * i)));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
  endtask

  task automatic wait_rd_done(input string tag);
    int b = 0;
    while (!rd_done && b < 200) begin tick(); b++; end
    check(tag, rd_done, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_empty"},   empty, 1);
    check({tag, "_full"},    full, 1);
    check({tag, "_rd_done"}, rd_done, 0);
    check({tag, "_wr_done"}, wr_done, 0);
    check({tag, "_rd_vld"},  mem_rd_req_valid, 0);
    check({tag, "_wr_vld"},  mem_wr_req_valid, 0);
    check({tag, "_rd_addr"}, mem_rd_req_addr, 0);
    check({tag, "_wr_addr"}, mem_wr_req_addr, 0);
    check({tag, "_wr_data"}, mem_wr_req_data, 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, wb, ab, b, seen;

    repeat (3) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();

    // 4-line read, sequential addresses
    rb = rd_log.size();
    rd_addr = 64'h1000; rd_size = 43'd4; rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    check("t1_busy", rd_done, 0);
    pop_lines(4, 64'h1000, "t1");
    wait_rd_done("t1_done");
    check("t1_nreq", rd_log.size() - rb, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_addr%0d", i), rd_at(rb + i), 64'h1000 + 64'(64 * i));

    // FIFO-depth throttling with a stalled peripheral
    rb = rd_log.size();
    rd_addr = 64'h2000; rd_size = 43'd40; rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    repeat (60) tick();
    check("t2_nreq16", rd_log.size() - rb, 16);
    check("t2_vld_off", mem_rd_req_valid, 0);
    check("t2_pop0", rd_data, pat(64'h2000));
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    repeat (10) tick();
    check("t2_nreq17", rd_log.size() - rb, 17);
    check("t2_vld_off2", mem_rd_req_valid, 0);
    pop_lines(39, 64'h2040, "t2");
    wait_rd_done("t2_done");

    // zero-size transfers on both channels together
    rb = rd_log.size(); wb = wr_alog.size();
    rd_size = 43'd0; wr_size = 43'd0; rd_addr = 64'h3000; wr_addr = 64'h3000;
    rd_go = 1'b1; wr_go = 1'b1;
    tick();
    rd_go = 1'b0; wr_go = 1'b0;
    check("t3_rd_busy", rd_done, 0);
    tick();
    check("t3_rd_done", rd_done, 1);
    check("t3_wr_done", wr_done, 1);
    check("t3_full", full, 1);
    repeat (5) tick();
    check("t3_rd_hold", rd_done, 1);
    check("t3_no_rd", rd_log.size() - rb, 0);
    check("t3_no_wr", wr_alog.size() - wb, 0);

    // write with memory backpressure
    wb = wr_alog.size(); ab = ack_cnt;
    mem_wr_req_ready = 1'b0;
    wr_addr = 64'h4000; wr_size = 43'd3; wr_go = 1'b1;
    tick();
    wr_go = 1'b0;
    check("t4_not_full", full, 0);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = wd(i);
      tick();
    end
    wr_data = wd(7);
    check("t4_full", full, 1);
    tick();
    wr_en = 1'b0;
    check("t4_vld", mem_wr_req_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_hold_addr%0d", i), mem_wr_req_addr, 64'h4000);
      check($sformatf("t4_hold_data%0d", i), mem_wr_req_data, wd(0));
      tick();
    end
    check("t4_not_done", wr_done, 0);
    mem_wr_req_ready = 1'b1;
    b = 0;
    while (!wr_done && b < 100) begin tick(); b++; end
    check("t4_done", wr_done, 1);
    check("t4_acks", ack_cnt - ab, 3);
    check("t4_nreq", wr_alog.size() - wb, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_addr%0d", i),
            (wb + i < wr_alog.size()) ? wr_alog[wb + i] : 64'hBAD, 64'h4000 + 64'(64 * i));
      check($sformatf("t4_wdata%0d", i),
            (wb + i < wr_dlog.size()) ? wr_dlog[wb + i] : '0, wd(i));
    end

    // address wrap; a second go while ACTIVE must be ignored
    rb = rd_log.size();
    rd_addr = 64'hFFFF_FFFF_FFFF_FFC0; rd_size = 43'd2; rd_go = 1'b1;
    tick();
    rd_addr = 64'h5555_0000; rd_size = 43'd9;
    tick();
    rd_go = 1'b0;
    pop_lines(2, 64'hFFFF_FFFF_FFFF_FFC0, "t5");
    wait_rd_done("t5_done");
    repeat (5) tick();
    check("t5_nreq", rd_log.size() - rb, 2);
    check("t5_addr0", rd_at(rb), 64'hFFFF_FFFF_FFFF_FFC0);
    check("t5_addr1", rd_at(rb + 1), 64'h0);

    // reset mid-transfer with three responses in flight
    rb = rd_log.size();
    rd_lat = 6;
    rd_addr = 64'h8000; rd_size = 43'd8; rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    b = 0;
    while (rd_log.size() - rb < 3 && b < 50) begin tick(); b++; end
    mem_rd_req_ready = 1'b0;
    check("t7_pending", rd_pend.size(), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("t7");
    mem_rd_req_ready = 1'b1;
    seen = 0; b = 0;
    while (rd_pend.size() > 0 && b < 50) begin
      tick(); b++;
      if (!empty || rd_data != '0) seen++;
    end
    repeat (3) tick();
    if (!empty || rd_data != '0) seen++;
    check("t7_drained", rd_pend.size(), 0);
    check("t7_discard", seen, 0);
    rd_lat = 2;

    // channel usable again after reset
    rd_addr = 64'h9000; rd_size = 43'd1; rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    pop_lines(1, 64'h9000, "t8");
    wait_rd_done("t8_done");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
